ram_boot_arbiter: RTL and testbench
===================================

Name: ram_boot_arbiter

Overview:
- Owns the single-port program/data RAM of the 16-bit RISC CPU and shares it between two requesters: the host loader port and the CPU memory port.
- Sequences the CPU: image load, then run via `cpu_E`, then halt with a sticky `done`.
- Replaces the ad-hoc `WR_RAM_E`/`E` gating at the CPU top level.
- Sits between the top-level host pins, the CPU core and the RAM macro.

Parameters:
- `STARVE_LIMIT`, 8: consecutive CPU grants allowed in RUN while host is pending before the host is forced one grant.
- `RUN_TIMEOUT`, 100000: RUN cycles without `cpu_halt` before forced halt; 0 disables.
- `AW`, 16: address width.
- `DW`, 16: data width.

Ports:
- `CLK`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous reset, active-high
- `host_req`  in  1  host access request
- `host_we`  in  1  host write (1) / read (0)
- `host_addr`  in  AW  host address
- `host_wdata`  in  DW  host write data
- `host_gnt`  out  1  host granted this cycle (combinational)
- `host_rvalid`  out  1  host read data valid
- `host_rdata`  out  DW  host read data
- `boot_start`  in  1  pulse: start/restart CPU
- `cpu_req`  in  1  CPU access request
- `cpu_we`  in  1  CPU write/read
- `cpu_addr`  in  AW  CPU address
- `cpu_wdata`  in  DW  CPU write data
- `cpu_gnt`  out  1  CPU granted (combinational)
- `cpu_rvalid`  out  1  CPU read data valid
- `cpu_rdata`  out  DW  CPU read data
- `cpu_halt`  in  1  CPU executed HALT
- `cpu_E`  out  1  CPU enable
- `done`  out  1  sticky run-complete
- `timeout`  out  1  sticky: halt was forced by watchdog
- `state`  out  2  0 IDLE, 1 LOAD, 2 RUN, 3 HALT
- `load_count`  out  16  granted host writes since reset or restart, saturating at 0xFFFF
- `ram_en`  out  1  RAM access strobe
- `ram_we`  out  1  RAM write
- `ram_addr`  out  AW  RAM address
- `ram_wdata`  out  DW  RAM write data
- `ram_rdata`  in  DW  RAM read data; synchronous, valid the cycle after a read access

Behaviour:
- **Reset** (async, `rst`=1):
  - `state`=IDLE; `cpu_E`, `done`, `timeout`, `host_rvalid`, `cpu_rvalid`=0.
  - `load_count`, starve counter and timeout counter=0.
  - Grants forced 0 while `rst` is high.
  - Any in-flight read is dropped: no `rvalid` after reset release.
- **Arbitration** (combinational, one access per cycle):
  - In IDLE, LOAD and HALT: `cpu_gnt`=0; `host_gnt`=`host_req`.
  - In RUN: `cpu_gnt`=`cpu_req`, unless the starve counter equals `STARVE_LIMIT` and `host_req`=1; then `host_gnt`=1 and `cpu_gnt`=0 for that cycle.
  - In RUN with `cpu_req`=0, `host_gnt`=`host_req`.
  - Starve counter: increments on each CPU grant while `host_req`=1; clears on any host grant or whenever `host_req`=0.
- **RAM port**:
  - `ram_en`=(`host_gnt` | `cpu_gnt`); `ram_we`/`ram_addr`/`ram_wdata` are muxed from the granted requester.
  - All RAM outputs are 0 when there is no grant.
- **Read return**:
  - Granted read registers the owner (host/CPU).
  - Next cycle the owner's `rvalid`=1 for exactly one cycle, with `rdata`=`ram_rdata`.
  - The non-owner's `rdata` holds its last value.
- **FSM** (registered):
  - IDLE→LOAD on a granted host write.
  - IDLE or LOAD→RUN on `boot_start`.
  - RUN→HALT on `cpu_halt`, or when the timeout counter reaches `RUN_TIMEOUT` (nonzero), which also sets `timeout`.
  - HALT→RUN on `boot_start`.
  - `boot_start` in RUN is ignored.
- **`cpu_E`**: 1 exactly while `state`=RUN, i.e. it rises the cycle after `boot_start` is sampled and falls the cycle after `cpu_halt` is sampled.
- **`done`**: set on entering HALT; cleared, together with `timeout` and `load_count`, on HALT→RUN restart.
- **Timeout counter**: counts RUN cycles; cleared on RUN entry.
- **Simultaneous events**:
  - `cpu_halt` and a timeout expiry in the same cycle: HALT with `timeout`=0 (halt wins).
  - `boot_start` together with a host write in IDLE: the write is performed and counted, and the state goes directly to RUN.
- **`load_count`**: increments in any non-RUN state on a granted host write.

Test Plan:
- Reset, then host writes 0x0000..0x0004 with data 0x1111..0x5555 → `state`=LOAD after the first write; `load_count`=5; RAM holds the data; `cpu_gnt` stays 0 even with `cpu_req`=1.
- `boot_start` pulse → `cpu_E`=1 the next cycle, `state`=2; CPU read of 0x0002 gives `cpu_rvalid` one cycle later with `cpu_rdata`=0x3333.
- In RUN, `cpu_req` held 1 and `host_req` held 1 (read of 0x0004) → 8 CPU grants, then 1 host grant; `host_rvalid` with 0x5555 the following cycle; pattern repeats.
- `cpu_halt` and `boot_start` asserted together in RUN → HALT, `done`=1, `cpu_E`=0; a later `boot_start` → RUN, `done`=0, `load_count`=0.
- `RUN_TIMEOUT`=16, no `cpu_halt` → HALT exactly 16 cycles after RUN entry, `timeout`=1, `done`=1.
- `rst` asserted mid-cycle during a pending CPU read → all outputs 0 immediately, `state`=IDLE, no `cpu_rvalid` after release.

Source files
------------

// File: rtl/ram_boot_arbiter.sv
// Shares the single-port program/data RAM between the host loader and the CPU,
// and sequences the CPU through image load, run and halt.
module ram_boot_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int RUN_TIMEOUT  = 100000,
    parameter int AW           = 16,
    parameter int DW           = 16
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    input  logic          boot_start,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          cpu_halt,
    output logic          cpu_E,
    output logic          done,
    output logic          timeout,
    output logic [1:0]    state,
    output logic [15:0]   load_count,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    localparam logic [15:0] STARVE_MAX   = 16'(STARVE_LIMIT);
    localparam logic [31:0] TIMEOUT_LAST = 32'(RUN_TIMEOUT - 1);
    localparam logic        TIMEOUT_EN   = (RUN_TIMEOUT != 0);

    state_t        state_r;
    state_t        state_s;
    logic [15:0]   starve_r;
    logic [31:0]   run_cnt_r;
    logic [DW-1:0] host_hold_r;
    logic [DW-1:0] cpu_hold_r;
    logic          host_wr_s;
    logic          expire_s;
    logic          restart_s;
    logic          enter_run_s;

    assign host_wr_s   = host_gnt & host_we;
    assign expire_s    = TIMEOUT_EN & (run_cnt_r == TIMEOUT_LAST);
    assign restart_s   = (state_r == ST_HALT) & boot_start;
    assign enter_run_s = (state_s == ST_RUN) & (state_r != ST_RUN);

    assign state      = 2'(state_r);
    assign ram_en     = host_gnt | cpu_gnt;
    assign host_rdata = host_rvalid ? ram_rdata : host_hold_r;
    assign cpu_rdata  = cpu_rvalid ? ram_rdata : cpu_hold_r;

    // Grant selection; the host steals one slot once the CPU has starved it.
    always_comb begin
        host_gnt = 1'b0;
        cpu_gnt  = 1'b0;
        if (rst) begin
            host_gnt = 1'b0;
            cpu_gnt  = 1'b0;
        end else if ((state_r == ST_RUN) && cpu_req &&
                     !((starve_r == STARVE_MAX) && host_req)) begin
            cpu_gnt = 1'b1;
        end else begin
            host_gnt = host_req;
        end
    end

    // RAM port mux from whichever requester holds the grant.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = {AW{1'b0}};
        ram_wdata = {DW{1'b0}};
        if (host_gnt) begin
            ram_we    = host_we;
            ram_addr  = host_addr;
            ram_wdata = host_wdata;
        end else if (cpu_gnt) begin
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end else begin
            ram_we    = 1'b0;
        end
    end

    // Sequencer next state; boot_start is deliberately ignored while running.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (boot_start)     state_s = ST_RUN;
                else if (host_wr_s) state_s = ST_LOAD;
                else                state_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (boot_start) state_s = ST_RUN;
                else            state_s = ST_LOAD;
            end
            ST_RUN: begin
                if (cpu_halt || expire_s) state_s = ST_HALT;
                else                      state_s = ST_RUN;
            end
            ST_HALT: begin
                if (boot_start) state_s = ST_RUN;
                else            state_s = ST_HALT;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Sequencer state, CPU enable, watchdog and sticky status.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cpu_E      <= 1'b0;
            run_cnt_r  <= 32'd0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            load_count <= 16'd0;
        end else begin
            state_r <= state_s;
            cpu_E   <= (state_s == ST_RUN);
            if (enter_run_s)             run_cnt_r <= 32'd0;
            else if (state_r == ST_RUN)  run_cnt_r <= run_cnt_r + 32'd1;
            else                         run_cnt_r <= run_cnt_r;
            if (restart_s)                                         done <= 1'b0;
            else if ((state_s == ST_HALT) && (state_r != ST_HALT)) done <= 1'b1;
            else                                                   done <= done;
            // An explicit halt in the expiry cycle takes precedence over the watchdog.
            if (restart_s)                                          timeout <= 1'b0;
            else if ((state_r == ST_RUN) && !cpu_halt && expire_s)  timeout <= 1'b1;
            else                                                    timeout <= timeout;
            if (restart_s)
                load_count <= 16'd0;
            else if ((state_r != ST_RUN) && host_wr_s && (load_count != 16'hFFFF))
                load_count <= load_count + 16'd1;
            else
                load_count <= load_count;
        end
    end

    // Starvation counter: CPU grants taken while the host is waiting.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            starve_r <= 16'd0;
        end else if (host_gnt || !host_req) begin
            starve_r <= 16'd0;
        end else if (cpu_gnt && (starve_r != 16'hFFFF)) begin
            starve_r <= starve_r + 16'd1;
        end else begin
            starve_r <= starve_r;
        end
    end

    // Read return: owner flagged for one cycle, last read data held per requester.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            host_rvalid <= 1'b0;
            cpu_rvalid  <= 1'b0;
            host_hold_r <= {DW{1'b0}};
            cpu_hold_r  <= {DW{1'b0}};
        end else begin
            host_rvalid <= host_gnt & ~host_we;
            cpu_rvalid  <= cpu_gnt & ~cpu_we;
            if (host_rvalid) host_hold_r <= ram_rdata;
            else             host_hold_r <= host_hold_r;
            if (cpu_rvalid)  cpu_hold_r  <= ram_rdata;
            else             cpu_hold_r  <= cpu_hold_r;
        end
    end

endmodule

// File: tb/tb_ram_boot_arbiter.sv
// Randomized bench for ram_boot_arbiter: a cycle-level reference model predicts
// grants/status, and read data goes through per-requester scoreboard queues.
module tb_ram_boot_arbiter;
    localparam int SL = 8;
    localparam int TO = 16;

    logic        CLK = 1'b0;
    logic        rst;
    logic        host_req, host_we, host_gnt, host_rvalid;
    logic [15:0] host_addr, host_wdata, host_rdata;
    logic        boot_start;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_halt, cpu_E, done, timeout;
    logic [1:0]  state;
    logic [15:0] load_count;
    logic        ram_en, ram_we;
    logic [15:0] ram_addr, ram_wdata, ram_rdata;

    always #5 CLK = ~CLK;

    ram_boot_arbiter #(.STARVE_LIMIT(SL), .RUN_TIMEOUT(TO), .AW(16), .DW(16)) dut (
        .CLK(CLK), .rst(rst),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .boot_start(boot_start),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .cpu_halt(cpu_halt), .cpu_E(cpu_E), .done(done), .timeout(timeout), .state(state),
        .load_count(load_count),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // Synchronous single-port RAM attached to the DUT's RAM port.
    logic [15:0] ram [0:65535];
    logic [15:0] ram_q = 16'h0000;
    assign ram_rdata = ram_q;
    always @(posedge CLK) begin
        if (ram_en) begin
            if (ram_we) ram[ram_addr] <= ram_wdata;
            else        ram_q <= ram[ram_addr];
        end
    end

    int total = 0;
    int bad   = 0;
    logic [15:0] hq[$];
    logic [15:0] cq[$];

    // Reference model state: 0 IDLE, 1 LOAD, 2 RUN, 3 HALT.
    int          m_state, m_starve, m_runcyc, m_lc;
    bit          m_done, m_to, m_hpend, m_cpend;
    logic [15:0] m_hval, m_cval, m_hhold, m_chold;
    logic [15:0] mmem [0:65535];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_starve = 0; m_runcyc = 0; m_lc = 0;
        m_done = 1'b0; m_to = 1'b0; m_hpend = 1'b0; m_cpend = 1'b0;
        m_hhold = 16'h0000; m_chold = 16'h0000;
        hq.delete();
        cq.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_host_gnt"}, 32'(host_gnt), 32'd0);
        chk({tag, "_cpu_gnt"}, 32'(cpu_gnt), 32'd0);
        chk({tag, "_ram_bus"}, {ram_en, ram_we, ram_addr, 14'(ram_wdata)}, 32'd0);
        chk({tag, "_rvalids"}, {30'd0, host_rvalid, cpu_rvalid}, 32'd0);
        chk({tag, "_rdatas"}, {host_rdata, cpu_rdata}, 32'd0);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_flags"}, {29'd0, cpu_E, done, timeout}, 32'd0);
        chk({tag, "_load_count"}, 32'(load_count), 32'd0);
    endtask

    task automatic zero_inputs();
        host_req = 1'b0; host_we = 1'b0; host_addr = 16'h0000; host_wdata = 16'h0000;
        boot_start = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000;
        cpu_wdata = 16'h0000; cpu_halt = 1'b0;
    endtask

    // Asserts reset partway through a cycle, checks everything collapses to zero.
    task automatic reset_mid();
        @(posedge CLK);
        #3;
        rst = 1'b1;
        #1;
        check_zero("mid_reset");
        zero_inputs();
        model_reset();
        repeat (2) @(negedge CLK);
        rst = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic cyc(input logic hr, input logic hwe, input logic [15:0] ha, input logic [15:0] hwd,
                       input logic bs, input logic cr, input logic cwe, input logic [15:0] ca,
                       input logic [15:0] cwd, input logic ch);
        bit          eh, ec, ewe;
        logic [15:0] ea, ed;
        @(negedge CLK);
        host_req = hr; host_we = hwe; host_addr = ha; host_wdata = hwd; boot_start = bs;
        cpu_req = cr; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cwd; cpu_halt = ch;
        #1;
        eh = 1'b0; ec = 1'b0;
        if (m_state == 2 && cr && !(m_starve == SL && hr)) ec = 1'b1;
        else                                               eh = hr;
        ewe = eh ? hwe : (ec ? cwe : 1'b0);
        ea  = eh ? ha  : (ec ? ca  : 16'h0000);
        ed  = eh ? hwd : (ec ? cwd : 16'h0000);
        chk("host_gnt", 32'(host_gnt), 32'(eh));
        chk("cpu_gnt", 32'(cpu_gnt), 32'(ec));
        chk("ram_ctl", {30'd0, ram_en, ram_we}, {30'd0, eh | ec, ewe});
        chk("ram_addr_wdata", {ram_addr, ram_wdata}, {ea, ed});
        chk("state", 32'(state), 32'(m_state));
        chk("cpu_E", 32'(cpu_E), 32'(m_state == 2));
        chk("done_timeout", {30'd0, done, timeout}, {30'd0, m_done, m_to});
        chk("load_count", 32'(load_count), 32'(m_lc));
        chk("rvalids", {30'd0, host_rvalid, cpu_rvalid}, {30'd0, m_hpend, m_cpend});
        if (!m_hpend) chk("host_rdata_hold", 32'(host_rdata), 32'(m_hhold));
        if (!m_cpend) chk("cpu_rdata_hold", 32'(cpu_rdata), 32'(m_chold));

        if (m_hpend) m_hhold = m_hval;
        if (m_cpend) m_chold = m_cval;
        m_hpend = eh && !hwe;
        m_cpend = ec && !cwe;
        if (m_hpend) begin m_hval = mmem[ha]; hq.push_back(m_hval); end
        if (m_cpend) begin m_cval = mmem[ca]; cq.push_back(m_cval); end
        if (eh && hwe) mmem[ha] = hwd;
        if (ec && cwe) mmem[ca] = cwd;
        if (eh || !hr) m_starve = 0;
        else if (ec)   m_starve++;
        if (m_state == 3 && bs)                                 m_lc = 0;
        else if (m_state != 2 && eh && hwe && m_lc < 65535)     m_lc++;
        case (m_state)
            0: if (bs) begin m_state = 2; m_runcyc = 0; end
               else if (eh && hwe) m_state = 1;
            1: if (bs) begin m_state = 2; m_runcyc = 0; end
            2: begin
                m_runcyc++;
                if (ch) begin m_state = 3; m_done = 1'b1; end
                else if (TO != 0 && m_runcyc == TO) begin m_state = 3; m_done = 1'b1; m_to = 1'b1; end
            end
            3: if (bs) begin m_state = 2; m_runcyc = 0; m_done = 1'b0; m_to = 1'b0; end
            default: m_state = 0;
        endcase
    endtask

    // Monitor: every rvalid must match the oldest predicted read for that requester.
    always @(negedge CLK) begin
        if (host_rvalid) begin
            if (hq.size() == 0) begin
                total++; bad++;
                $display("FAIL host_rdata: host_rvalid with no read outstanding, got %0h", host_rdata);
            end else chk("host_rdata", 32'(host_rdata), 32'(hq.pop_front()));
        end
        if (cpu_rvalid) begin
            if (cq.size() == 0) begin
                total++; bad++;
                $display("FAIL cpu_rdata: cpu_rvalid with no read outstanding, got %0h", cpu_rdata);
            end else chk("cpu_rdata", 32'(cpu_rdata), 32'(cq.pop_front()));
        end
    end

    initial begin
        for (int i = 0; i < 65536; i++) mmem[i] = 16'h0000;
        zero_inputs();
        model_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #2;
        check_zero("reset");
        repeat (2) @(negedge CLK);
        rst = 1'b0;

        cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 1'b1, 16'(i), 16'(16'h1111 * (i + 1)), 1'b0, 1'b1, 1'b0, 16'h1, 16'h0, 1'b0);
        cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        for (int i = 5; i < 8; i++)
            cyc(1'b1, 1'b1, 16'(i), 16'($urandom), 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h2, 16'h0, 1'b0);
        cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (12) cyc(1'b1, 1'b0, 16'h4, 16'h0, 1'b0, 1'b1, 1'b0, 16'($urandom_range(0, 7)), 16'h0, 1'b0);
        cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        repeat (2) cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (10) cyc(1'b1, 1'b0, 16'h4, 16'h0, 1'b0, 1'b1, 1'b0, 16'($urandom_range(0, 7)), 16'h0, 1'b0);
        repeat (10) cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);

        cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h3, 16'h0, 1'b0);
        reset_mid();
        cyc(1'b1, 1'b1, 16'h6, 16'hBEEF, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);

        for (int n = 0; n < 800; n++)
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 7)), 16'($urandom),
                1'($urandom_range(0, 19) == 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 7)), 16'($urandom),
                1'($urandom_range(0, 24) == 0));
        repeat (3) cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        chk("host_queue_drained", 32'(hq.size()), 32'd0);
        chk("cpu_queue_drained", 32'(cq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
